// File: rtl/ks_mp_add_seq_pkg.sv
// Shared types and width helpers for the multi-precision add sequencer.
// Build option KS_MP_SUB_EN (subtract mode) is handled in the interface and top.
package ks_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int N_DEF     = 4;
    localparam int WORDS_DEF = 4;

    function automatic int calc_w(input int n, input int words);
        return n * words;
    endfunction

    // A single-chunk build still needs a 1-bit index register.
    function automatic int calc_idx_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/ks_mp_add_seq_if.sv
// Request/result handshake bundle for ks_mp_add_seq; slave = sequencer side.
// KS_MP_SUB_EN adds the in_sub request field.
interface ks_mp_add_seq_if #(parameter int W = 16);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
`ifdef KS_MP_SUB_EN
    logic         in_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;

    modport slave (
`ifdef KS_MP_SUB_EN
        input  in_sub,
`endif
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, busy
    );

    modport master (
`ifdef KS_MP_SUB_EN
        output in_sub,
`endif
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, busy
    );

endinterface

// File: rtl/ks_mp_add_seq_chunk_add.sv
// N-bit Kogge-Stone adder with carry-in, sum[N] is the carry-out.
// Purely combinational: zero latency, no backpressure.
module ks_chunk_add #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N:0]   sum
);

    localparam int L = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] p0;
    logic [N-1:0] g;
    logic [N-1:0] pp;
    logic [N-1:0] gn;
    logic [N-1:0] pn;
    logic [N:0]   c;

    // cin is folded into bit 0's generate so the prefix tree yields carries directly.
    always_comb begin
        p0    = a ^ b;
        g     = a & b;
        g[0]  = g[0] | (p0[0] & cin);
        pp    = p0;
        gn    = g;
        pn    = pp;
        for (int s = 0; s < L; s++) begin
            gn = g;
            pn = pp;
            for (int i = (1 << s); i < N; i++) begin
                gn[i] = g[i] | (pp[i] & g[i - (1 << s)]);
                pn[i] = pp[i] & pp[i - (1 << s)];
            end
            g  = gn;
            pp = pn;
        end
        c   = {g, cin};
        sum = {c[N], p0 ^ c[N-1:0]};
    end

endmodule

// File: rtl/ks_mp_add_seq.sv
// Wide A+B+cin over WORDS cycles, one N-bit chunk per cycle, LS chunk first.
// Latency: out_valid WORDS cycles after accept; one op in flight, in_ready low while busy.
// Result held in DONE until out_ready; KS_MP_SUB_EN adds in_sub for A-B.
module ks_mp_add_seq
    import ks_seq_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic            clk,
    input  logic            rst,
    ks_mp_add_seq_if.slave  bus
);

    localparam int W  = calc_w(N, WORDS);
    localparam int IW = calc_idx_w(WORDS);

    state_e          state_q, state_d;
    logic [W-1:0]    a_sh_q, a_sh_d;
    logic [W-1:0]    b_sh_q, b_sh_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    out_sum_q, out_sum_d;
    logic            carry_q, carry_d;
    logic            out_cout_q, out_cout_d;
    logic            out_valid_q, out_valid_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [N-1:0]    b_chunk;
    logic [N:0]      res;
    logic            in_ready;
`ifdef KS_MP_SUB_EN
    logic            sub_q, sub_d;
`endif

    assign in_ready = !rst && (state_q == IDLE);

`ifdef KS_MP_SUB_EN
    assign b_chunk = sub_q ? ~b_sh_q[N-1:0] : b_sh_q[N-1:0];
`else
    assign b_chunk = b_sh_q[N-1:0];
`endif

    ks_chunk_add #(.N(N)) u_chunk_add (
        .a   (a_sh_q[N-1:0]),
        .b   (b_chunk),
        .cin (carry_q),
        .sum (res)
    );

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        acc_d       = acc_q;
        out_sum_d   = out_sum_q;
        carry_d     = carry_q;
        out_cout_d  = out_cout_q;
        out_valid_d = out_valid_q;
        idx_d       = idx_q;
`ifdef KS_MP_SUB_EN
        sub_d       = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready) begin
                    a_sh_d  = bus.in_a;
                    b_sh_d  = bus.in_b;
                    idx_d   = '0;
                    state_d = RUN;
`ifdef KS_MP_SUB_EN
                    sub_d   = bus.in_sub;
                    carry_d = bus.in_sub | bus.in_cin;
                    if (bus.in_sub) carry_d = 1'b1;
`else
                    carry_d = bus.in_cin;
`endif
                end
            end
            RUN: begin
                // Chunk results enter at the top so chunk 0 ends in the low bits.
                acc_d   = (acc_q >> N) | (W'(res[N-1:0]) << (W - N));
                a_sh_d  = a_sh_q >> N;
                b_sh_d  = b_sh_q >> N;
                carry_d = res[N];
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(WORDS - 1)) begin
                    out_sum_d   = acc_d;
                    out_cout_d  = res[N];
                    out_valid_d = 1'b1;
                    idx_d       = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            acc_q       <= '0;
            out_sum_q   <= '0;
            carry_q     <= 1'b0;
            out_cout_q  <= 1'b0;
            out_valid_q <= 1'b0;
            idx_q       <= '0;
`ifdef KS_MP_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            acc_q       <= acc_d;
            out_sum_q   <= out_sum_d;
            carry_q     <= carry_d;
            out_cout_q  <= out_cout_d;
            out_valid_q <= out_valid_d;
            idx_q       <= idx_d;
`ifdef KS_MP_SUB_EN
            sub_q       <= sub_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cout  = out_cout_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
